// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter front end.
// Debouncer state encoding, display-mode codes and the counter range limits.
package counter_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } dbState_t;

   localparam logic MODE_DEC = 1'b0;
   localparam logic MODE_HEX = 1'b1;

   localparam logic [CNT_W-1:0] HEX_MAX = 16'hFFFF;

   // Upper count limit for the given display mode.
   function automatic logic [CNT_W-1:0] modeMax(input logic mode, input logic [CNT_W-1:0] decMax);
      return (mode == MODE_HEX) ? HEX_MAX : decMax;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer plus a stable-sample debounce FSM.
// Outputs the registered debounced level (held) and a press pulse on acceptance.
module btn_debounce
   import counter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btnRaw,
   output logic held,
   output logic press_c
);

   localparam int unsigned TMR_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       syncQ;
   logic             syncLvl;
   logic             armed;
   dbState_t         state;
   logic [TMR_W-1:0] timer;

   // Synchronizer resets to "pressed" so a button held through reset is not taken as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) syncQ <= 2'b11;
      else        syncQ <= {syncQ[0], btnRaw};
   end

   assign syncLvl = syncQ[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
         held  <= 1'b0;
         armed <= 1'b0;
      end else begin
         armed <= armed | ~syncLvl;
         case (state)
            IDLE: begin
               if (syncLvl && armed) begin
                  state <= CONFIRM;
                  timer <= '0;
               end
            end
            CONFIRM: begin
               if (!syncLvl) begin
                  state <= IDLE;
               end else if (timer == TMR_LAST) begin
                  state <= HELD;
                  held  <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            HELD: begin
               if (!syncLvl) begin
                  state <= RELEASE;
                  held  <= 1'b0;
                  timer <= '0;
               end
            end
            RELEASE: begin
               if (syncLvl) begin
                  state <= HELD;
                  held  <= 1'b1;
               end else if (timer == TMR_LAST) begin
                  state <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Press fires on the CONFIRM->HELD transition so f moves on the very next edge.
   assign press_c = (state == CONFIRM) && syncLvl && (timer == TMR_LAST);

endmodule

// File: rtl/updown_count_ctrl.sv
// Debounced inc/dec/mode buttons driving the 16-bit display value f and displayMode.
// Define AUTO_REPEAT_EN to auto-repeat inc/dec while a single button is held.
module updown_count_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned DEC_MAX         = 9999,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic             btn_mode,
   output logic [CNT_W-1:0] f,
   output logic             displayMode,
   output logic             step
);

   localparam logic [CNT_W-1:0] DEC_MAX_V = CNT_W'(DEC_MAX);

   logic [1:0]       rstSync;
   logic             rstInt_n;
   logic             incHeld, decHeld, modeHeld;
   logic             incPress_c, decPress_c, modePress_c;
   logic             incStep_c, decStep_c;
   logic             unusedBits_c;
   logic [CNT_W-1:0] curMax_c, stepped_c, fNext_c;
   logic             modeNext_c;

   // Async assert, synchronous release of the internal reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rstSync <= 2'b00;
      else        rstSync <= {rstSync[0], 1'b1};
   end

   assign rstInt_n = rstSync[1];

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIncDb (
      .clk(clk), .rst_n(rstInt_n), .btnRaw(btn_inc), .held(incHeld), .press_c(incPress_c)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDecDb (
      .clk(clk), .rst_n(rstInt_n), .btnRaw(btn_dec), .held(decHeld), .press_c(decPress_c)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeDb (
      .clk(clk), .rst_n(rstInt_n), .btnRaw(btn_mode), .held(modeHeld), .press_c(modePress_c)
   );

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

   logic [REP_W-1:0] repCnt;
   logic [REP_W-1:0] repLimit_c;
   logic             repArmed;
   logic             repActive_c;
   logic             repFire_c;

   // Repeats only while exactly one of inc/dec is held; first gap is the longer delay.
   assign repActive_c = incHeld ^ decHeld;
   assign repLimit_c  = repArmed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
   assign repFire_c   = repActive_c && (repCnt == repLimit_c);

   always_ff @(posedge clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         repCnt   <= '0;
         repArmed <= 1'b0;
      end else if (!repActive_c) begin
         repCnt   <= '0;
         repArmed <= 1'b0;
      end else if (repFire_c) begin
         repCnt   <= '0;
         repArmed <= 1'b1;
      end else begin
         repCnt   <= repCnt + REP_W'(1);
      end
   end

   assign incStep_c    = incPress_c | (repFire_c & incHeld);
   assign decStep_c    = decPress_c | (repFire_c & decHeld);
   assign unusedBits_c = modeHeld;
`else
   assign incStep_c    = incPress_c;
   assign decStep_c    = decPress_c;
   assign unusedBits_c = ^{modeHeld, incHeld, decHeld, 1'(REPEAT_DELAY), 1'(REPEAT_PERIOD)};
`endif

   // Step with the current mode's range first, then apply toggle and decimal clamp.
   always_comb begin
      curMax_c   = modeMax(displayMode, DEC_MAX_V);
      stepped_c  = f;
      modeNext_c = displayMode;
      if (incStep_c && !decStep_c) begin
         stepped_c = (f == curMax_c) ? '0 : f + CNT_W'(1);
      end else if (decStep_c && !incStep_c) begin
         stepped_c = (f == '0) ? curMax_c : f - CNT_W'(1);
      end
      if (modePress_c) modeNext_c = ~displayMode;
      fNext_c = stepped_c;
      if ((modeNext_c == MODE_DEC) && (stepped_c > DEC_MAX_V)) fNext_c = '0;
   end

   always_ff @(posedge clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         f           <= '0;
         displayMode <= MODE_DEC;
         step        <= 1'b0;
      end else begin
         f           <= fNext_c;
         displayMode <= modeNext_c;
         step        <= (fNext_c != f);
      end
   end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench for updown_count_ctrl with a short debounce and repeat timing.
// Expected values come from a modular-arithmetic model of the counter rules.
module tb_updown_count_ctrl;

   logic        clk;
   logic        rst_n;
   logic        btnInc, btnDec, btnMode;
   logic [15:0] f;
   logic        displayMode;
   logic        step;

   int nCompared;
   int nMismatched;
   int mF;
   bit mMode;

   updown_count_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .DEC_MAX(9999),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_inc(btnInc), .btn_dec(btnDec), .btn_mode(btnMode),
      .f(f), .displayMode(displayMode), .step(step)
   );

   always #5 clk = ~clk;

   // Counter rules expressed as modular arithmetic over the active range.
   task automatic modelApply(input bit i, input bit d, input bit m);
      int modv;
      modv = (mMode ? 65535 : 9999) + 1;
      if (i && !d)      mF = (mF + 1) % modv;
      else if (d && !i) mF = (mF + modv - 1) % modv;
      if (m) begin
         mMode = !mMode;
         if (!mMode && mF > 9999) mF = 0;
      end
   endtask

   task automatic applyReset();
      rst_n = 1'b0; btnInc = 1'b0; btnDec = 1'b0; btnMode = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      mF = 0; mMode = 1'b0;
   endtask

   // One full press/release of the chosen buttons; counts step cycles seen.
   task automatic doPress(input bit i, input bit d, input bit m, output int steps);
      steps = 0;
      @(negedge clk);
      btnInc = i; btnDec = d; btnMode = m;
      repeat (10) begin
         @(negedge clk);
         if (step === 1'b1) steps++;
      end
      btnInc = 1'b0; btnDec = 1'b0; btnMode = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (step === 1'b1) steps++;
      end
   endtask

   task automatic pressAndCheck(input string tag, input bit i, input bit d, input bit m);
      int steps, oldF, expSteps;
      oldF = mF;
      doPress(i, d, m, steps);
      modelApply(i, d, m);
      expSteps = (mF != oldF) ? 1 : 0;
      nCompared++;
      if (f !== 16'(mF)) begin
         nMismatched++;
         $display("FAIL %s f: got %0d want %0d", tag, f, mF);
      end
      nCompared++;
      if (displayMode !== mMode) begin
         nMismatched++;
         $display("FAIL %s displayMode: got %0b want %0b", tag, displayMode, mMode);
      end
      nCompared++;
      if (steps != expSteps) begin
         nMismatched++;
         $display("FAIL %s step count: got %0d want %0d", tag, steps, expSteps);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btnInc = 1'b0; btnDec = 1'b0; btnMode = 1'b0;
      repeat (3) @(negedge clk);
      nCompared++;
      if ({f, displayMode, step} !== 18'd0) begin
         nMismatched++;
         $display("FAIL reset_hold outputs: got f=%0d mode=%0b step=%0b want 0/0/0", f, displayMode, step);
      end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      mF = 0; mMode = 1'b0;
      nCompared++;
      if ({f, displayMode, step} !== 18'd0) begin
         nMismatched++;
         $display("FAIL reset_release outputs: got f=%0d mode=%0b step=%0b want 0/0/0", f, displayMode, step);
      end
   endtask

   task automatic test_clean_inc();
      logic [15:0] fSeen [1:10];
      logic        sSeen [1:10];
      @(negedge clk);
      btnInc = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         fSeen[n] = f;
         sSeen[n] = step;
      end
      btnInc = 1'b0;
      repeat (12) @(negedge clk);
      nCompared++;
      if (fSeen[6] !== 16'd0) begin
         nMismatched++;
         $display("FAIL latency_early f: got %0d want 0", fSeen[6]);
      end
      nCompared++;
      if (fSeen[7] !== 16'd1 || sSeen[7] !== 1'b1) begin
         nMismatched++;
         $display("FAIL latency_edge f/step: got %0d/%0b want 1/1", fSeen[7], sSeen[7]);
      end
      nCompared++;
      if (sSeen[8] !== 1'b0) begin
         nMismatched++;
         $display("FAIL step_width: got %0b want 0", sSeen[8]);
      end
      modelApply(1'b1, 1'b0, 1'b0);
      pressAndCheck("clean_inc2", 1'b1, 1'b0, 1'b0);
      pressAndCheck("clean_inc3", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_mid_press_reset();
      int steps;
      @(negedge clk);
      btnInc = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nCompared++;
      if (f !== 16'd0 || displayMode !== 1'b0) begin
         nMismatched++;
         $display("FAIL async_reset f/mode: got %0d/%0b want 0/0", f, displayMode);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mF = 0; mMode = 1'b0;
      steps = 0;
      repeat (20) begin
         @(negedge clk);
         if (step === 1'b1) steps++;
      end
      btnInc = 1'b0;
      repeat (12) @(negedge clk);
      nCompared++;
      if (f !== 16'd0 || steps != 0) begin
         nMismatched++;
         $display("FAIL held_through_reset f/steps: got %0d/%0d want 0/0", f, steps);
      end
      pressAndCheck("repress_after_reset", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      int steps;
      steps = 0;
      @(negedge clk);
      btnInc = 1'b1;
      repeat (2) @(negedge clk);
      btnInc = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (step === 1'b1) steps++;
      end
      nCompared++;
      if (f !== 16'(mF) || steps != 0) begin
         nMismatched++;
         $display("FAIL glitch f/steps: got %0d/%0d want %0d/0", f, steps, mF);
      end
   endtask

   task automatic test_dec_wrap();
      applyReset();
      pressAndCheck("dec_from_0", 1'b0, 1'b1, 1'b0);
      pressAndCheck("inc_from_9999", 1'b1, 1'b0, 1'b0);
      pressAndCheck("dec_wrap_again", 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_hex();
      pressAndCheck("inc_to_0", 1'b1, 1'b0, 1'b0);
      pressAndCheck("mode_to_hex", 1'b0, 1'b0, 1'b1);
      pressAndCheck("hex_dec_wrap", 1'b0, 1'b1, 1'b0);
      pressAndCheck("mode_clamp", 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_cancel();
      int bad;
      for (int n = 0; n < 5; n++) pressAndCheck("cancel_setup", 1'b1, 1'b0, 1'b0);
      bad = 0;
      @(negedge clk);
      btnInc = 1'b1; btnDec = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (step !== 1'b0 || f !== 16'd5) bad++;
      end
      btnInc = 1'b0; btnDec = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (step !== 1'b0 || f !== 16'd5) bad++;
      end
      nCompared++;
      if (bad != 0 || f !== 16'(mF)) begin
         nMismatched++;
         $display("FAIL cancel f/bad_cycles: got %0d/%0d want %0d/0", f, bad, mF);
      end
   endtask

   task automatic test_coincident();
      logic [2:0] codes [8];
      codes = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b101};
      foreach (codes[n]) begin
         logic [2:0] c;
         c = codes[n];
         pressAndCheck($sformatf("coincident_%0d", n), c[2], c[1], c[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [2:0] c;
         c = 3'($urandom_range(7, 1));
         pressAndCheck($sformatf("random_%0d", n), c[2], c[1], c[0]);
      end
   endtask

   task automatic test_repeat();
      int expF;
      applyReset();
      @(negedge clk);
      btnInc = 1'b1;
      repeat (7) @(negedge clk);
      nCompared++;
      if (f !== 16'd1) begin
         nMismatched++;
         $display("FAIL repeat_first f: got %0d want 1", f);
      end
      expF = 1;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
`ifdef AUTO_REPEAT_EN
         expF = (k >= 20) ? 2 + (k - 20) / 5 : 1;
`else
         expF = 1;
`endif
         nCompared++;
         if (f !== 16'(expF)) begin
            nMismatched++;
            $display("FAIL repeat_k%0d f: got %0d want %0d", k, f, expF);
         end
      end
      btnInc = 1'b0;
      repeat (20) @(negedge clk);
      nCompared++;
      if (f !== 16'(expF)) begin
         nMismatched++;
         $display("FAIL repeat_after_release f: got %0d want %0d", f, expF);
      end
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      btnInc = 1'b0; btnDec = 1'b0; btnMode = 1'b0;
      nCompared = 0; nMismatched = 0;
      mF = 0; mMode = 1'b0;
      test_reset();
      test_clean_inc();
      test_mid_press_reset();
      test_glitch();
      test_dec_wrap();
      test_hex();
      test_cancel();
      test_coincident();
      test_random();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
